// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with guard slots, blanking, blinking and
// frame-synchronous double-buffered content updates.
module seg_scan_display #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  IN_clk,
  input  logic                  IN_rst,
  input  logic [4*DIGITS-1:0]   IN_value,
  input  logic [DIGITS-1:0]     IN_dp,
  input  logic [3:0]            IN_off_number,
  input  logic [DIGITS-1:0]     IN_blink_mask,
  input  logic                  IN_load,
  output logic [DIGITS-1:0]     OUT_choice,
  output logic [7:0]            OUT_seg,
  output logic                  OUT_busy
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);

  logic [ScanW-1:0]    scan_q, scan_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic                slot_end, frame_end;

  logic [4*DIGITS-1:0] sh_value_q, pd_value_q;
  logic [DIGITS-1:0]   sh_dp_q, pd_dp_q;
  logic [3:0]          sh_off_q, pd_off_q;
  logic [DIGITS-1:0]   sh_mask_q, pd_mask_q;
  logic                busy_q;

  always_comb begin
    slot_end    = (scan_q == ScanLast);
    frame_end   = slot_end && (idx_q == IdxLast);
    scan_d      = slot_end ? '0 : scan_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    // Blink disabled entirely when BLINK_FRAMES is zero: phase never leaves 0.
    if (frame_end && (BLINK_FRAMES != 0)) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      scan_q      <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_off_q    <= '0;
      sh_mask_q   <= '0;
      pd_value_q  <= '0;
      pd_dp_q     <= '0;
      pd_off_q    <= '0;
      pd_mask_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      if (frame_end) begin
        // A load landing exactly on the frame edge bypasses pending (newest wins).
        if (IN_load) begin
          sh_value_q <= IN_value;
          sh_dp_q    <= IN_dp;
          sh_off_q   <= IN_off_number;
          sh_mask_q  <= IN_blink_mask;
          busy_q     <= 1'b0;
        end else if (busy_q) begin
          sh_value_q <= pd_value_q;
          sh_dp_q    <= pd_dp_q;
          sh_off_q   <= pd_off_q;
          sh_mask_q  <= pd_mask_q;
          busy_q     <= 1'b0;
        end
      end else if (IN_load) begin
        pd_value_q <= IN_value;
        pd_dp_q    <= IN_dp;
        pd_off_q   <= IN_off_number;
        pd_mask_q  <= IN_blink_mask;
        busy_q     <= 1'b1;
      end
    end
  end

  logic [3:0] nib;
  logic [7:0] pat;
  logic [4:0] off_sum;
  logic       blank;
  logic       guard;

  always_comb begin
    nib     = sh_value_q[{idx_q, 2'b00} +: 4];
    off_sum = 5'(sh_off_q) + 5'(idx_q);
    blank   = (off_sum >= 5'(DIGITS)) || (blink_ph_q && sh_mask_q[idx_q]);
    guard   = (scan_q < ScanW'(GUARD));
    unique case (nib)
      4'h0: pat = 8'h03;
      4'h1: pat = 8'h9F;
      4'h2: pat = 8'h25;
      4'h3: pat = 8'h0D;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h49;
      4'h6: pat = 8'h41;
      4'h7: pat = 8'h1F;
      4'h8: pat = 8'h01;
      4'h9: pat = 8'h09;
      4'hA: pat = 8'h11;
      4'hB: pat = 8'hC1;
      4'hC: pat = 8'h63;
      4'hD: pat = 8'h85;
      4'hE: pat = 8'h61;
      default: pat = 8'h71;
    endcase
    OUT_choice = '0;
    OUT_seg    = 8'hFF;
    if (!guard) begin
      OUT_choice = DIGITS'(1) << idx_q;
      if (!blank) begin
        OUT_seg = {pat[7:1], ~sh_dp_q[idx_q]};
      end
    end
    OUT_busy = busy_q;
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a reference model pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_seg_scan_display;

  localparam int unsigned Digits = 4;
  localparam int unsigned Frame  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic [3:0]  in_off = '0;
  logic [3:0]  in_mask = '0;
  logic        in_load = 1'b0;
  logic [3:0]  out_choice;
  logic [7:0]  out_seg;
  logic        out_busy;

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];

  // Reference model state
  int          pos = 0;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_off, p_off, m_mask, p_mask;
  logic        m_busy, m_ph;
  int          m_bcnt;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  seg_scan_display #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .GUARD        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .IN_clk        (clk),
    .IN_rst        (rst),
    .IN_value      (in_value),
    .IN_dp         (in_dp),
    .IN_off_number (in_off),
    .IN_blink_mask (in_mask),
    .IN_load       (in_load),
    .OUT_choice    (out_choice),
    .OUT_seg       (out_seg),
    .OUT_busy      (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] expect_at(input int p);
    int   k, s;
    logic blank;
    logic [3:0] nib;
    logic [7:0] seg;
    k = p / 4;
    s = p % 4;
    if (s < 1) return {4'b0000, 8'hFF, m_busy};
    blank = ((k + int'(m_off)) >= Digits) || (m_ph && m_mask[k]);
    nib = m_val[k*4 +: 4];
    seg = seg_tab[nib];
    if (m_dp[k]) seg[0] = 1'b0;
    if (blank) seg = 8'hFF;
    return {4'(1 << k), seg, m_busy};
  endfunction

  // One clock: advance the model with the inputs present at this edge.
  task automatic tick();
    logic rst_s, load_s, fe;
    rst_s  = rst;
    load_s = in_load;
    @(posedge clk);
    #1;
    if (rst_s) begin
      pos = 0; m_busy = 0; m_ph = 0; m_bcnt = 0;
      m_val = '0; m_dp = '0; m_off = '0; m_mask = '0;
      p_val = '0; p_dp = '0; p_off = '0; p_mask = '0;
    end else begin
      fe  = (pos == Frame - 1);
      pos = (pos + 1) % Frame;
      if (fe) begin
        if (m_bcnt == 1) begin m_bcnt = 0; m_ph = ~m_ph; end
        else m_bcnt = m_bcnt + 1;
        if (load_s) begin
          m_val = in_value; m_dp = in_dp; m_off = in_off; m_mask = in_mask; m_busy = 0;
        end else if (m_busy) begin
          m_val = p_val; m_dp = p_dp; m_off = p_off; m_mask = p_mask; m_busy = 0;
        end
      end else if (load_s) begin
        p_val = in_value; p_dp = in_dp; p_off = in_off; p_mask = in_mask; m_busy = 1;
      end
    end
    exp_q.push_back(expect_at(pos));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 2 * Frame; i++) begin
      if (pos == p) break;
      tick();
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] off,
                      input logic [3:0] mask);
    in_value = v; in_dp = dp; in_off = off; in_mask = mask; in_load = 1'b1;
    tick();
    in_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      check_val("scan", {out_choice, out_seg, out_busy}, e);
    end
  end

  initial begin
    m_val = '0; m_dp = '0; m_off = '0; m_mask = '0; m_busy = 0; m_ph = 0; m_bcnt = 0;
    p_val = '0; p_dp = '0; p_off = '0; p_mask = '0;
    // Reset then idle
    rst = 1'b1;
    run(2);
    check_val("rst_choice", out_choice, 4'h0);
    check_val("rst_seg", out_seg, 8'hFF);
    check_val("rst_busy", out_busy, 1'b0);
    rst = 1'b0;
    tick();
    check_val("first_digit0", {out_choice, out_seg}, {4'h1, 8'h03});
    run(2 * Frame - 1);

    // Deferred update issued during digit 1
    run_to(5);
    load(16'h1A2F, 4'b0010, 4'd0, 4'b0000);
    check_val("busy_set", out_busy, 1'b1);
    check_val("old_shown", out_seg, 8'h03);
    run_to(1);
    check_val("d0_new", {out_choice, out_seg, out_busy}, {4'h1, 8'h71, 1'b0});
    run_to(5);
    check_val("d1_dp", out_seg, 8'h24);
    run_to(9);
    check_val("d2_new", out_seg, 8'h11);
    run_to(13);
    check_val("d3_new", out_seg, 8'h9F);
    run(Frame);

    // Leading-digit blanking
    run_to(6);
    load(16'h1A2F, 4'b0010, 4'd2, 4'b0000);
    run(2 * Frame);
    run_to(13);
    check_val("off2_d3", out_seg, 8'hFF);
    run_to(6);
    load(16'h1A2F, 4'b0010, 4'd7, 4'b0000);
    run(2 * Frame);
    run_to(5);
    check_val("off7_d1", {out_choice, out_seg}, {4'h2, 8'hFF});

    // Blink on digit 0
    run_to(3);
    load(16'h1A2F, 4'b0010, 4'd0, 4'b0001);
    run(9 * Frame);

    // Load at the frame-end edge while an older update is pending
    run_to(5);
    load(16'h3333, 4'b0000, 4'd0, 4'b0000);
    run_to(15);
    load(16'h5555, 4'b0000, 4'd0, 4'b0000);
    check_val("fe_busy", out_busy, 1'b0);
    tick();
    check_val("fe_new", out_seg, 8'h49);
    run(Frame);

    // Reset during digit 2 with an update pending, load ignored under reset
    run_to(2);
    load(16'h8888, 4'b1111, 4'd0, 4'b0000);
    run_to(10);
    check_val("pre_rst_busy", out_busy, 1'b1);
    rst = 1'b1;
    in_load = 1'b1;
    tick();
    rst = 1'b0;
    in_load = 1'b0;
    check_val("rst_mid", {out_choice, out_seg, out_busy}, {4'h0, 8'hFF, 1'b0});
    tick();
    check_val("rst_after", {out_choice, out_seg}, {4'h1, 8'h03});
    run(2 * Frame);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
